// File: rtl/concot_lane_fifo_array_pkg.sv
// concot_pkg: shared sizing and bus-slicing helpers for the lane FIFO array.
package concot_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lvl_w(input int depth);
    return clog2(depth + 1);
  endfunction
  function automatic int lane_lsb(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/concot_lane_fifo.sv
// concot_lane_fifo: one elastic FIFO lane with explicit level and a sticky full-stall detector.
module concot_lane_fifo
  import concot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit REVERSE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          din,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      ovf_seen
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int CW = LW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  logic push, pop, stall;
  logic [WIDTH-1:0] head;
  assign in_ready = level != FULL;
  assign out_valid = level != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign stall = in_valid & ~in_ready;
  assign head = mem[rd];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign dout[i] = REVERSE ? head[WIDTH-1-i] : head[i];
  end
  // cnt saturates one past DEPTH; ovf_seen sets on the edge that takes it beyond DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      if (!rst_n) ovf_seen <= 1'b0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      cnt <= !stall ? '0 : (cnt > CW'(DEPTH)) ? cnt : cnt + 1'b1;
      if (stall && cnt >= CW'(DEPTH)) ovf_seen <= 1'b1;
    end
  end
endmodule

// File: rtl/concot_lane_fifo_array.sv
// concot_lane_fifo_array: NUM_CH independent FIFO lanes on concatenated buses, lane 0 in the LSBs.
module concot_lane_fifo_array
  import concot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_CH = 8,
  parameter int DEPTH = 4,
  parameter bit REVERSE = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [NUM_CH*WIDTH-1:0]          inp,
  input  logic [NUM_CH-1:0]                in_valid,
  output logic [NUM_CH-1:0]                in_ready,
  output logic [NUM_CH*WIDTH-1:0]          otp,
  output logic [NUM_CH-1:0]                out_valid,
  input  logic [NUM_CH-1:0]                out_ready,
  output logic [NUM_CH*lvl_w(DEPTH)-1:0]   level,
  output logic [NUM_CH-1:0]                ovf_seen
);
  localparam int LW = lvl_w(DEPTH);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    concot_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REVERSE(REVERSE)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .din       (inp[lane_lsb(c, WIDTH) +: WIDTH]),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .dout      (otp[lane_lsb(c, WIDTH) +: WIDTH]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .level     (level[lane_lsb(c, LW) +: LW]),
      .ovf_seen  (ovf_seen[c])
    );
  end
endmodule

// File: tb/tb_concot_lane_fifo_array.sv
// tb_concot_lane_fifo_array: directed checks of the lane FIFO array, plus a REVERSE=1 instance.
module tb_concot_lane_fifo_array;
  localparam int W = 8, N = 8, D = 4, LW = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush;
  logic [N*W-1:0] inp, otp;
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, ovf_seen;
  logic [N*LW-1:0] level;
  logic [W-1:0] r_inp, r_otp;
  logic [0:0] r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_ovf;
  logic [LW-1:0] r_level;
  int total = 0, bad = 0;

  concot_lane_fifo_array #(.WIDTH(W), .NUM_CH(N), .DEPTH(D), .REVERSE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inp(inp), .in_valid(in_valid),
    .in_ready(in_ready), .otp(otp), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf_seen(ovf_seen)
  );
  concot_lane_fifo_array #(.WIDTH(W), .NUM_CH(1), .DEPTH(D), .REVERSE(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inp(r_inp), .in_valid(r_in_valid),
    .in_ready(r_in_ready), .otp(r_otp), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .level(r_level), .ovf_seen(r_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [LW-1:0] lvl(input int c);
    return level[c*LW +: LW];
  endfunction
  function automatic logic [W-1:0] head(input int c);
    return otp[c*W +: W];
  endfunction

  logic [W-1:0] q [N][$];
  int pushed [N], popped [N];
  bit done;
  logic [W-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst_n = 1'b0; flush = 1'b0; inp = '0; in_valid = '1; out_ready = '0;
    r_inp = '0; r_in_valid = '0; r_out_ready = '0;
    step; step;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 8'hFF);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf_seen, 0);
    chk("rst_otp", otp, 0);
    rst_n = 1'b1; in_valid = '0;
    step;
    // lane 3 fill then drain
    for (int k = 0; k < 4; k++) begin
      inp = '0; inp[3*W +: W] = fill[k]; in_valid = 8'h08;
      step;
    end
    in_valid = '0;
    chk("fill_level", level, 24'(4) << (3*LW));
    chk("fill_in_ready", in_ready, 8'hF7);
    chk("fill_out_valid", out_valid, 8'h08);
    out_ready = 8'h08;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", out_valid[3], 1);
      chk("drain_data", head(3), fill[k]);
      step;
    end
    chk("drain_empty", out_valid[3], 0);
    out_ready = '0;
    // all lanes, 6 words each, random backpressure, wraps pointers
    foreach (pushed[c]) begin pushed[c] = 0; popped[c] = 0; end
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      for (int c = 0; c < N; c++) begin
        in_valid[c] = pushed[c] < 6;
        inp[c*W +: W] = 8'(c*16 + pushed[c] + 1);
        out_ready[c] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < N; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          q[c].push_back(inp[c*W +: W]);
          pushed[c]++;
        end
        if (out_valid[c] && out_ready[c]) begin
          if (q[c].size() == 0) chk("seq_extra", head(c), 8'hXX);
          else chk("seq_data", head(c), q[c].pop_front());
          popped[c]++;
        end
      end
      step;
      done = 1'b1;
      for (int c = 0; c < N; c++) if (popped[c] < 6) done = 1'b0;
    end
    for (int c = 0; c < N; c++) chk("seq_count", 64'(popped[c]), 6);
    in_valid = '0; out_ready = '0;
    // full lane 1: push with pop refuses the push
    for (int k = 0; k < 4; k++) begin
      inp = '0; inp[W +: W] = 8'(8'hA1 + k); in_valid = 8'h02;
      step;
    end
    inp[W +: W] = 8'hEE; out_ready = 8'h02;
    step;
    chk("fullpp_level", lvl(1), 3);
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("fullpp_data", head(1), 8'(8'hA2 + k));
      step;
    end
    chk("fullpp_empty", out_valid[1], 0);
    out_ready = '0;
    // flush drops same-cycle push
    for (int k = 0; k < 3; k++) begin
      inp = '0; inp[W-1:0] = 8'(8'h61 + k); in_valid = 8'h01;
      step;
    end
    chk("pre_flush_level", lvl(0), 3);
    inp[W-1:0] = 8'h99; flush = 1'b1;
    step;
    flush = 1'b0; in_valid = '0;
    chk("flush_level", lvl(0), 0);
    chk("flush_valid", out_valid[0], 0);
    inp[W-1:0] = 8'h55; in_valid = 8'h01;
    step;
    in_valid = '0;
    chk("post_flush_head", head(0), 8'h55);
    chk("post_flush_level", lvl(0), 1);
    flush = 1'b1; step; flush = 1'b0;
    // reversed output lane
    r_inp = 8'h01; r_in_valid = 1'b1;
    step;
    chk("rev_01", r_otp, 8'h80);
    r_inp = 8'hA0; r_out_ready = 1'b1;
    step;
    r_in_valid = 1'b0; r_out_ready = 1'b0;
    chk("rev_a0", r_otp, 8'h05);
    chk("rev_level", r_level, 1);
    // overflow on lane 5
    for (int k = 0; k < 4; k++) begin
      inp = '0; inp[5*W +: W] = 8'(k); in_valid = 8'h20;
      step;
    end
    chk("ovf_full", in_ready, 8'hDF);
    for (int k = 0; k < 4; k++) step;
    chk("ovf_pre", ovf_seen, 0);
    step;
    chk("ovf_set", ovf_seen, 8'h20);
    in_valid = '0; flush = 1'b1;
    step;
    flush = 1'b0;
    chk("ovf_after_flush", ovf_seen, 8'h20);
    chk("flush_all_level", level, 0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("ovf_after_rst", ovf_seen, 0);
    chk("rev_rst_level", r_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
